// File: rtl/light_transition_guard_pkg.sv
// Shared light codes, guard state encoding and code sanitising helpers
// for the light transition guard.
package light_transition_guard_pkg;

  localparam logic [2:0] LC_STOP  = 3'b000;
  localparam logic [2:0] LC_FWD   = 3'b001;
  localparam logic [2:0] LC_LEFT  = 3'b010;
  localparam logic [2:0] LC_RIGHT = 3'b011;
  localparam logic [2:0] LC_GO    = 3'b100;

  localparam int N_DIR = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SHOW  = 1'b1
  } guard_state_t;

  function automatic logic is_illegal(input logic [2:0] code);
    return code > LC_GO;
  endfunction

  function automatic logic [2:0] sanitise(input logic [2:0] code);
    return is_illegal(code) ? LC_STOP : code;
  endfunction

endpackage

// File: rtl/light_transition_guard_if.sv
// Request/display bundle between the light-decision logic (master)
// and the transition guard (slave).
interface light_transition_guard_if;
  logic [2:0] req_N;
  logic [2:0] req_S;
  logic [2:0] req_E;
  logic [2:0] req_W;
  logic [2:0] outN;
  logic [2:0] outS;
  logic [2:0] outE;
  logic [2:0] outW;
  logic       in_clear;
  logic       bad_code;
  logic [7:0] n_commits;

  modport master (
    output req_N, req_S, req_E, req_W,
    input  outN, outS, outE, outW, in_clear, bad_code, n_commits
  );

  modport slave (
    input  req_N, req_S, req_E, req_W,
    output outN, outS, outE, outW, in_clear, bad_code, n_commits
  );
endinterface

// File: rtl/light_transition_guard_timer.sv
// Saturating up-counter with load, shared by the clearance and hold timing;
// o_at_limit is high once the count has reached the current limit.
module light_transition_guard_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt < i_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt >= i_limit);

endmodule

// File: rtl/light_transition_guard.sv
// Safety stage after the light-decision logic: enforces a minimum display time
// and an all-Stop clearance before any movement-granting change.
module light_transition_guard
  import light_transition_guard_pkg::*;
#(
  parameter int MIN_HOLD     = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input logic                   clk,
  input logic                   rst,
  light_transition_guard_if.slave bus
);

  logic [N_DIR-1:0][2:0] w_req_raw;
  logic [N_DIR-1:0][2:0] w_req_san;
  logic [N_DIR-1:0][2:0] r_req_q;
  logic [N_DIR-1:0][2:0] r_out;
  logic [N_DIR-1:0]      w_dir_bad;
  logic [N_DIR-1:0]      w_dir_diff;
  logic [N_DIR-1:0]      w_dir_grant;
  guard_state_t          r_state;
  logic                  r_in_clear;
  logic                  r_bad_code;
  logic [7:0]            r_n_commits;

  logic                  w_any_diff;
  logic                  w_reduce_only;
  logic                  w_tmr_at_limit;
  logic                  w_clear_done;
  logic                  w_show_change;
  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;
  logic [CNT_W-1:0]      w_tmr_limit;

  assign w_req_raw = {bus.req_W, bus.req_E, bus.req_S, bus.req_N};

  // A direction "grants" when it differs and asks for anything but Stop.
  generate
    for (genvar gi = 0; gi < N_DIR; gi++) begin : g_dir
      assign w_req_san[gi]   = sanitise(w_req_raw[gi]);
      assign w_dir_bad[gi]   = is_illegal(w_req_raw[gi]);
      assign w_dir_diff[gi]  = (r_req_q[gi] != r_out[gi]);
      assign w_dir_grant[gi] = w_dir_diff[gi] && (r_req_q[gi] != LC_STOP);
    end
  endgenerate

  assign w_any_diff    = |w_dir_diff;
  assign w_reduce_only = ~|w_dir_grant;

  assign w_clear_done  = (r_state == ST_CLEAR) && w_tmr_at_limit;
  assign w_show_change = (r_state == ST_SHOW) && w_tmr_at_limit && w_any_diff;
  assign w_tmr_load    = w_clear_done || w_show_change;
  assign w_tmr_val     = (w_clear_done || w_reduce_only) ? CNT_W'(1) : '0;
  // In CLEAR the count starts at 0, so the last clear cycle sits at CLEAR_CYCLES-1.
  assign w_tmr_limit   = (r_state == ST_CLEAR) ? CNT_W'(CLEAR_CYCLES - 1) : CNT_W'(MIN_HOLD);

  light_transition_guard_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_limit    (w_tmr_limit),
    .o_at_limit (w_tmr_at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_q     <= '0;
      r_out       <= '0;
      r_state     <= ST_CLEAR;
      r_in_clear  <= 1'b1;
      r_bad_code  <= 1'b0;
      r_n_commits <= '0;
    end else begin
      r_req_q <= w_req_san;
      if (|w_dir_bad) begin
        r_bad_code <= 1'b1;
      end
      case (r_state)
        ST_CLEAR: begin
          if (w_clear_done) begin
            r_out      <= r_req_q;
            r_state    <= ST_SHOW;
            r_in_clear <= 1'b0;
            if (r_n_commits != 8'hFF) r_n_commits <= r_n_commits + 8'd1;
          end
        end
        ST_SHOW: begin
          if (w_show_change) begin
            if (w_reduce_only) begin
              r_out <= r_req_q;
              if (r_n_commits != 8'hFF) r_n_commits <= r_n_commits + 8'd1;
            end else begin
              r_out      <= '0;
              r_state    <= ST_CLEAR;
              r_in_clear <= 1'b1;
            end
          end
        end
        default: begin
          r_out      <= '0;
          r_state    <= ST_CLEAR;
          r_in_clear <= 1'b1;
        end
      endcase
    end
  end

  assign bus.outN      = r_out[0];
  assign bus.outS      = r_out[1];
  assign bus.outE      = r_out[2];
  assign bus.outW      = r_out[3];
  assign bus.in_clear  = r_in_clear;
  assign bus.bad_code  = r_bad_code;
  assign bus.n_commits = r_n_commits;

endmodule

// File: tb/tb_light_transition_guard.sv
// Scoreboard bench for light_transition_guard: a cycle model pushes expected
// outputs each edge, a monitor pops and compares them mid-cycle.
module tb_light_transition_guard;
  import light_transition_guard_pkg::*;

  localparam int MIN_HOLD     = 4;
  localparam int CLEAR_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  light_transition_guard_if bus ();

  light_transition_guard #(
    .MIN_HOLD     (MIN_HOLD),
    .CLEAR_CYCLES (CLEAR_CYCLES),
    .CNT_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [11:0] out;
    logic        in_clear;
    logic        bad;
    logic [7:0]  n;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {bus.outW, bus.outE, bus.outS, bus.outN};
  endfunction

  // ---------------- reference model ----------------
  logic [2:0] m_req[4];
  logic [2:0] m_out[4];
  logic [2:0] m_raw[4];
  bit         m_in_clear;
  bit         m_bad;
  int         m_clear_left;
  int         m_age;
  int         m_n;
  bit         m_changed;
  bit         m_grant;
  exp_t       m_exp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        m_req[d] = 3'b000;
        m_out[d] = 3'b000;
      end
      m_in_clear   = 1'b1;
      m_bad        = 1'b0;
      m_clear_left = CLEAR_CYCLES;
      m_age        = 0;
      m_n          = 0;
      sb_q.delete();
    end else begin
      if (m_in_clear) begin
        if (m_clear_left == 1) begin
          m_out      = m_req;
          m_in_clear = 1'b0;
          m_age      = 1;
          if (m_n < 255) m_n++;
        end else begin
          m_clear_left--;
        end
      end else begin
        m_changed = 1'b0;
        m_grant   = 1'b0;
        for (int d = 0; d < 4; d++) begin
          if (m_req[d] != m_out[d]) begin
            m_changed = 1'b1;
            if (m_req[d] != 3'b000) m_grant = 1'b1;
          end
        end
        if (m_age >= MIN_HOLD && m_changed) begin
          if (!m_grant) begin
            m_out = m_req;
            m_age = 1;
            if (m_n < 255) m_n++;
          end else begin
            for (int d = 0; d < 4; d++) m_out[d] = 3'b000;
            m_in_clear   = 1'b1;
            m_clear_left = CLEAR_CYCLES;
          end
        end else if (m_age < MIN_HOLD) begin
          m_age++;
        end
      end
      m_raw[0] = bus.req_N;
      m_raw[1] = bus.req_S;
      m_raw[2] = bus.req_E;
      m_raw[3] = bus.req_W;
      for (int d = 0; d < 4; d++) begin
        if (m_raw[d] > 3'b100) begin
          m_bad    = 1'b1;
          m_req[d] = 3'b000;
        end else begin
          m_req[d] = m_raw[d];
        end
      end
      m_exp.out      = {m_out[3], m_out[2], m_out[1], m_out[0]};
      m_exp.in_clear = m_in_clear;
      m_exp.bad      = m_bad;
      m_exp.n        = 8'(m_n);
      sb_q.push_back(m_exp);
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
    end else begin
      mon_e = '{out: 12'h000, in_clear: 1'b1, bad: 1'b0, n: 8'h00};
    end
    check_val("out",       32'(dut_out()),     32'(mon_e.out));
    check_val("in_clear",  32'(bus.in_clear),  32'(mon_e.in_clear));
    check_val("bad_code",  32'(bus.bad_code),  32'(mon_e.bad));
    check_val("n_commits", 32'(bus.n_commits), 32'(mon_e.n));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_req(input logic [2:0] n, input logic [2:0] s,
                         input logic [2:0] e, input logic [2:0] w);
    bus.req_N = n;
    bus.req_S = s;
    bus.req_E = e;
    bus.req_W = w;
  endtask

  initial begin
    set_req(3'b010, 3'b100, 3'b000, 3'b011);
    step(3);
    check_val("rst_in_clear", 32'(bus.in_clear), 32'd1);
    check_val("rst_out",      32'(dut_out()),    32'h000);
    rst = 1'b1;

    // Test 1: initial clearance then commit
    step(1);
    check_val("t1_clear_mid", 32'(bus.in_clear), 32'd1);
    step(1);
    check_val("t1_outN",  32'(bus.outN),      32'(3'b010));
    check_val("t1_outS",  32'(bus.outS),      32'(3'b100));
    check_val("t1_outW",  32'(bus.outW),      32'(3'b011));
    check_val("t1_clear", 32'(bus.in_clear),  32'd0);
    check_val("t1_n",     32'(bus.n_commits), 32'd1);

    // Test 2: reduce-only change, no clearance
    step(4);
    set_req(3'b010, 3'b000, 3'b000, 3'b011);
    step(1);
    check_val("t2_outS_hold", 32'(bus.outS), 32'(3'b100));
    step(1);
    check_val("t2_outS",  32'(bus.outS),      32'(3'b000));
    check_val("t2_clear", 32'(bus.in_clear),  32'd0);
    check_val("t2_n",     32'(bus.n_commits), 32'd2);

    // Test 3: granting change goes through clearance
    step(4);
    set_req(3'b010, 3'b000, 3'b100, 3'b011);
    step(2);
    check_val("t3_clear1", 32'(bus.in_clear), 32'd1);
    check_val("t3_stop",   32'(dut_out()),    32'h000);
    step(1);
    check_val("t3_clear2", 32'(bus.in_clear), 32'd1);
    step(1);
    check_val("t3_outE", 32'(bus.outE),      32'(3'b100));
    check_val("t3_outN", 32'(bus.outN),      32'(3'b010));
    check_val("t3_n",    32'(bus.n_commits), 32'd3);

    // Test 4: change right after a commit waits for the hold
    set_req(3'b010, 3'b000, 3'b100, 3'b000);
    step(3);
    check_val("t4_outW_hold", 32'(bus.outW), 32'(3'b011));
    step(1);
    check_val("t4_outW", 32'(bus.outW),      32'(3'b000));
    check_val("t4_n",    32'(bus.n_commits), 32'd4);

    // Test 5: illegal code sanitised and flagged
    set_req(3'b111, 3'b000, 3'b100, 3'b000);
    step(1);
    check_val("t5_bad", 32'(bus.bad_code), 32'd1);
    step(5);
    check_val("t5_outN",   32'(bus.outN),      32'(3'b000));
    check_val("t5_n",      32'(bus.n_commits), 32'd5);
    check_val("t5_sticky", 32'(bus.bad_code),  32'd1);

    // Test 6: async reset mid-CLEAR and mid-SHOW
    set_req(3'b001, 3'b000, 3'b100, 3'b000);
    for (int i = 0; i < 20 && !bus.in_clear; i++) step(1);
    check_val("t6_reach_clear", 32'(bus.in_clear), 32'd1);
    #1 rst = 1'b0;
    #1;
    check_val("t6a_out", 32'(dut_out()),     32'h000);
    check_val("t6a_n",   32'(bus.n_commits), 32'd0);
    check_val("t6a_bad", 32'(bus.bad_code),  32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    check_val("t6a_rel_clear", 32'(bus.in_clear), 32'd1);
    step(1);
    check_val("t6a_rel_clear2", 32'(bus.in_clear), 32'd1);
    step(1);
    check_val("t6a_outN", 32'(bus.outN),      32'(3'b001));
    check_val("t6a_n",    32'(bus.n_commits), 32'd1);
    step(2);
    #1 rst = 1'b0;
    #1;
    check_val("t6b_out",   32'(dut_out()),     32'h000);
    check_val("t6b_n",     32'(bus.n_commits), 32'd0);
    check_val("t6b_clear", 32'(bus.in_clear),  32'd1);
    @(posedge clk);
    #2 rst = 1'b1;

    // Saturation of the commit counter
    for (int i = 0; i < 200; i++) begin
      set_req(3'b000, 3'b000, 3'b100, 3'b000);
      step(8);
      set_req(3'b001, 3'b000, 3'b100, 3'b000);
      step(8);
    end
    check_val("sat_n", 32'(bus.n_commits), 32'hFF);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
